// File: rtl/dram_perf_seq_pkg.sv
// dram_perf_pkg: shared types and constants for the DRAM performance test sequencer.
//   perf_mode_t : command mode encoding (WR, RD, WR_THEN_RD, ILLEGAL)
//   seq_state_t : sequencer state encoding
//   ADDR_MASK   : 30-bit beat-address window
//   ACC_W       : width of the cycle-count accumulators
package dram_perf_pkg;

    typedef enum logic [1:0] {
        WR         = 2'd0,
        RD         = 2'd1,
        WR_THEN_RD = 2'd2,
        ILLEGAL    = 2'd3
    } perf_mode_t;

    typedef enum logic [2:0] {
        IDLE, WR_RUN, WR_REL, RD_RUN, RD_REL, NEXT, REPORT, ERR
    } seq_state_t;

    localparam logic [29:0] ADDR_MASK = 30'h3fff_ffff;
    localparam int          ACC_W     = 48;

endpackage

// File: rtl/dram_perf_seq_if.sv
// dram_perf_seq_if: command, controller and result signals of the DRAM test sequencer.
//   master : the sequencer's view (accepts commands, drives the controller, reports results)
//   slave  : the environment's view (issues commands, plays the controller, consumes results)
interface dram_perf_seq_if #(
    parameter int ITER_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [31:0]       cmd_addr;
    logic [31:0]       cmd_len;
    logic [31:0]       cmd_val;
    logic [ITER_W-1:0] cmd_iter;
    logic              wr_enable;
    logic              rd_enable;
    logic              wr_done;
    logic              rd_done;
    logic [31:0]       start_addr;
    logic [31:0]       burst_len;
    logic [31:0]       write_val;
    logic [31:0]       rhash;
    logic [31:0]       rd_clk_count;
    logic [31:0]       wr_clk_count;
    logic              busy;
    logic              res_valid;
    logic [31:0]       res_rhash;
    logic [47:0]       res_rd_cycles;
    logic [47:0]       res_wr_cycles;
    logic [ITER_W-1:0] res_iters;
    logic              res_err;

    modport master (
        input  cmd_valid, cmd_mode, cmd_addr, cmd_len, cmd_val, cmd_iter,
        input  wr_done, rd_done, rhash, rd_clk_count, wr_clk_count,
        output cmd_ready, wr_enable, rd_enable, start_addr, burst_len, write_val,
        output busy, res_valid, res_rhash, res_rd_cycles, res_wr_cycles, res_iters, res_err
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_addr, cmd_len, cmd_val, cmd_iter,
        output wr_done, rd_done, rhash, rd_clk_count, wr_clk_count,
        input  cmd_ready, wr_enable, rd_enable, start_addr, burst_len, write_val,
        input  busy, res_valid, res_rhash, res_rd_cycles, res_wr_cycles, res_iters, res_err
    );
endinterface

// File: rtl/dram_perf_seq_acc.sv
// dram_perf_acc: 48-bit clear/add accumulator with a 32-bit addend, wrapping modulo 2^48.
//   clk, rst : clock and synchronous active-high reset
//   clr_i    : clear to zero (wins over add)
//   add_i    : add val_i this cycle
//   val_i    : 32-bit addend
//   acc_o    : registered running sum
module dram_perf_acc
    import dram_perf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [31:0]      val_i,
    output logic [ACC_W-1:0] acc_o
);
    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb acc_d = clr_i ? '0 : add_i ? acc_q + ACC_W'(val_i) : acc_q;

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/dram_perf_seq.sv
// dram_perf_seq: test sequencer driving the DRAM controller's wr/rd enable handshake per iteration.
//   clk, rst : clock and synchronous active-high reset
//   bus      : dram_perf_seq_if.master -- command handshake, controller enables/done/run
//              parameters/per-run results, busy and the accumulated result record
//   TIMEOUT_CYCLES : per-run watchdog limit, active only with DRAM_PERF_SEQ_TIMEOUT_EN defined
//   ITER_W         : iteration count width
// Macro DRAM_PERF_SEQ_TIMEOUT_EN adds a per-run watchdog that aborts into a sticky ERR state.
module dram_perf_seq
    import dram_perf_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000,
    parameter int          ITER_W         = 16
) (
    input  logic            clk,
    input  logic            rst,
    dram_perf_seq_if.master bus
);
    seq_state_t        state_q, state_d;
    perf_mode_t        mode_q, mode_d;
    logic [ITER_W-1:0] iter_q, iter_d, iter_max_q, iter_max_d;
    logic [31:0]       start_addr_q, start_addr_d, burst_len_q, burst_len_d;
    logic [31:0]       write_val_q, write_val_d, rhash_q, rhash_d;
    logic              err_q, err_d, arm_q, arm_d;
    logic              cmd_ready_q, wr_enable_q, rd_enable_q, busy_q, res_valid_q;
    logic              accept, wr_hit, rd_hit, entering;
`ifdef DRAM_PERF_SEQ_TIMEOUT_EN
    logic [31:0]       wd_q, wd_d;
`endif

    assign accept = state_q == IDLE && cmd_ready_q && bus.cmd_valid;
    // arm_q records that done was seen low during this run, so a stale done is never counted
    assign wr_hit = state_q == WR_RUN && arm_q && bus.wr_done;
    assign rd_hit = state_q == RD_RUN && arm_q && bus.rd_done;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        iter_d       = iter_q;
        iter_max_d   = iter_max_q;
        start_addr_d = start_addr_q;
        burst_len_d  = burst_len_q;
        write_val_d  = write_val_q;
        rhash_d      = rhash_q;
        err_d        = err_q;
        case (state_q)
            IDLE: if (accept) begin
                mode_d       = perf_mode_t'(bus.cmd_mode);
                iter_d       = '0;
                iter_max_d   = bus.cmd_iter == '0 ? ITER_W'(1) : bus.cmd_iter;
                start_addr_d = {2'b0, bus.cmd_addr[29:0] & ADDR_MASK};
                burst_len_d  = {2'b0, bus.cmd_len[29:0]};
                write_val_d  = bus.cmd_val;
                rhash_d      = '0;
                err_d        = mode_d == ILLEGAL;
                state_d      = mode_d == ILLEGAL ? REPORT : mode_d == RD ? RD_RUN : WR_RUN;
            end
            WR_RUN: if (wr_hit) state_d = WR_REL;
            WR_REL: if (!bus.wr_done) state_d = mode_q == WR_THEN_RD ? RD_RUN : NEXT;
            RD_RUN: if (rd_hit) begin
                rhash_d = rhash_q ^ bus.rhash;
                state_d = RD_REL;
            end
            RD_REL: if (!bus.rd_done) state_d = NEXT;
            NEXT: begin
                iter_d = iter_q + ITER_W'(1);
                if (iter_d == iter_max_q) state_d = REPORT;
                else begin
                    start_addr_d = {2'b0, (start_addr_q[29:0] + burst_len_q[29:0] + 30'd1) & ADDR_MASK};
                    write_val_d  = write_val_q + 32'd1;
                    state_d      = mode_q == RD ? RD_RUN : WR_RUN;
                end
            end
            REPORT:  state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
`ifdef DRAM_PERF_SEQ_TIMEOUT_EN
        // a done arriving on the limit cycle still completes the run normally
        if (((state_q == WR_RUN && !wr_hit) || (state_q == RD_RUN && !rd_hit)) &&
            wd_q + 32'd1 == TIMEOUT_CYCLES) begin
            state_d = ERR;
            err_d   = 1'b1;
        end
`endif
    end

    assign entering = (state_d == WR_RUN || state_d == RD_RUN) && state_d != state_q;

    // on entry, arm only if the relevant done is already low at this edge
    always_comb arm_d = entering ? !(state_d == RD_RUN ? bus.rd_done : bus.wr_done)
                                 : arm_q | !(state_q == RD_RUN ? bus.rd_done : bus.wr_done);

`ifdef DRAM_PERF_SEQ_TIMEOUT_EN
    always_comb wd_d = entering ? '0 : (state_q == WR_RUN || state_q == RD_RUN) ? wd_q + 32'd1 : wd_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= WR;
            iter_q       <= '0;
            iter_max_q   <= '0;
            start_addr_q <= '0;
            burst_len_q  <= '0;
            write_val_q  <= '0;
            rhash_q      <= '0;
            err_q        <= 1'b0;
            arm_q        <= 1'b0;
            cmd_ready_q  <= 1'b0;
            wr_enable_q  <= 1'b0;
            rd_enable_q  <= 1'b0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
`ifdef DRAM_PERF_SEQ_TIMEOUT_EN
            wd_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            iter_q       <= iter_d;
            iter_max_q   <= iter_max_d;
            start_addr_q <= start_addr_d;
            burst_len_q  <= burst_len_d;
            write_val_q  <= write_val_d;
            rhash_q      <= rhash_d;
            err_q        <= err_d;
            arm_q        <= arm_d;
            // outputs are registered copies of next-state decodes
            cmd_ready_q  <= state_d == IDLE && !bus.wr_done && !bus.rd_done;
            wr_enable_q  <= state_d == WR_RUN;
            rd_enable_q  <= state_d == RD_RUN;
            busy_q       <= state_d != IDLE;
            res_valid_q  <= state_d == REPORT || (state_d == ERR && state_q != ERR);
`ifdef DRAM_PERF_SEQ_TIMEOUT_EN
            wd_q         <= wd_d;
`endif
        end
    end

    dram_perf_acc u_rd_acc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .add_i (rd_hit),
        .val_i (bus.rd_clk_count),
        .acc_o (bus.res_rd_cycles)
    );

    dram_perf_acc u_wr_acc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .add_i (wr_hit),
        .val_i (bus.wr_clk_count),
        .acc_o (bus.res_wr_cycles)
    );

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.wr_enable  = wr_enable_q;
    assign bus.rd_enable  = rd_enable_q;
    assign bus.start_addr = start_addr_q;
    assign bus.burst_len  = burst_len_q;
    assign bus.write_val  = write_val_q;
    assign bus.busy       = busy_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_rhash  = rhash_q;
    assign bus.res_iters  = iter_q;
    assign bus.res_err    = err_q;
endmodule

// File: tb/tb_dram_perf_seq.sv
// tb_dram_perf_seq: randomized scoreboard bench for dram_perf_seq with a behavioural controller model.
module tb_dram_perf_seq;
    localparam int ITER_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_perf_seq_if #(.ITER_W(ITER_W)) b ();

    dram_perf_seq #(.TIMEOUT_CYCLES(20), .ITER_W(ITER_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    typedef struct {
        logic        rd;
        logic [31:0] addr, len, val, cnt, hash;
        int          lat, rel;
        bit          hang;
    } run_t;

    typedef struct {
        logic [31:0] rhash;
        logic [47:0] rd, wr;
        logic [15:0] iters;
        logic        err;
    } res_t;

    run_t run_q[$];
    res_t res_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   fix_en = 0;
    logic [31:0] fix_wc, fix_rc, fix_h;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: expands a command into its controller runs and final record using plain arithmetic.
    task automatic model_cmd(input logic [1:0] mode, input logic [31:0] addr, len, val, input logic [15:0] iter);
        longint unsigned a = addr & 32'h3fff_ffff;
        longint unsigned l = len & 32'h3fff_ffff;
        longint unsigned ws = 0, rs = 0;
        logic [31:0] v = val, hx = 0;
        int n = iter == 0 ? 1 : int'(iter);
        run_t r;
        if (mode == 2'd3) begin
            res_q.push_back('{32'h0, 48'h0, 48'h0, 16'h0, 1'b1});
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 2; k++) begin
                if ((k == 0 && mode == 2'd1) || (k == 1 && mode == 2'd0)) continue;
                r.rd   = k[0];
                r.addr = 32'(a);
                r.len  = 32'(l);
                r.val  = v;
                r.cnt  = fix_en ? (k == 1 ? fix_rc : fix_wc) : $urandom;
                r.hash = fix_en ? fix_h : $urandom;
                r.lat  = $urandom_range(0, 5);
                r.rel  = $urandom_range(0, 2);
                r.hang = 0;
                run_q.push_back(r);
                if (k == 1) begin
                    rs = (rs + r.cnt) % (64'd1 << 48);
                    hx ^= r.hash;
                end else ws = (ws + r.cnt) % (64'd1 << 48);
            end
            a = (a + l + 1) % (64'd1 << 30);
            v = v + 32'd1;
        end
        res_q.push_back('{hx, 48'(rs), 48'(ws), 16'(n), 1'b0});
    endtask

    task automatic issue(input logic [1:0] mode, input logic [31:0] addr, len, val, input logic [15:0] iter);
        int t = 0;
        while (!b.cmd_ready && t < 200) begin @(negedge clk); t++; end
        check("cmd_ready_wait", 64'(t < 200), 1);
        b.cmd_mode  = mode;
        b.cmd_addr  = addr;
        b.cmd_len   = len;
        b.cmd_val   = val;
        b.cmd_iter  = iter;
        b.cmd_valid = 1'b1;
        @(negedge clk);
        b.cmd_valid = 1'b0;
        check("busy_after_accept", b.busy, 1);
    endtask

    task automatic run_cmd(input logic [1:0] mode, input logic [31:0] addr, len, val, input logic [15:0] iter);
        int t = 0;
        model_cmd(mode, addr, len, val, iter);
        issue(mode, addr, len, val, iter);
        if (mode == 2'd3) check("illegal_pulse_next_cycle", b.res_valid, 1);
        while (b.busy && t < 5000) begin @(negedge clk); t++; end
        check("cmd_complete", 64'(t < 5000), 1);
        check("runs_consumed", run_q.size(), 0);
        check("result_seen", res_q.size(), 0);
    endtask

    // Controller model: serves one queued run per enable, checks run parameters.
    run_t ctl_r;
    int   ctl_t;
    bit   ctl_rd;
    initial begin
        b.wr_done = 0; b.rd_done = 0; b.rhash = 0; b.rd_clk_count = 0; b.wr_clk_count = 0;
        forever begin
            @(negedge clk);
            if (!rst && (b.wr_enable || b.rd_enable)) begin
                ctl_rd = b.rd_enable;
                if (run_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_run: got wr_enable=%0d rd_enable=%0d expected no run", b.wr_enable, b.rd_enable);
                    ctl_t = 0;
                    while ((b.wr_enable || b.rd_enable) && ctl_t < 1000) begin @(negedge clk); ctl_t++; end
                end else begin
                    ctl_r = run_q.pop_front();
                    check("run_kind", 64'(ctl_rd), 64'(ctl_r.rd));
                    check("start_addr", b.start_addr, ctl_r.addr);
                    check("burst_len", b.burst_len, ctl_r.len);
                    if (ctl_rd) check("wr_done_low_at_rd", b.wr_done, 0);
                    else        check("write_val", b.write_val, ctl_r.val);
                    ctl_t = 0;
                    if (ctl_r.hang) begin
                        while ((b.wr_enable || b.rd_enable) && ctl_t < 1000) begin @(negedge clk); ctl_t++; end
                    end else begin
                        repeat (ctl_r.lat) @(negedge clk);
                        if (ctl_rd) begin
                            b.rd_clk_count = ctl_r.cnt; b.rhash = ctl_r.hash; b.rd_done = 1;
                        end else begin
                            b.wr_clk_count = ctl_r.cnt; b.wr_done = 1;
                        end
                        while ((ctl_rd ? b.rd_enable : b.wr_enable) && ctl_t < 1000) begin @(negedge clk); ctl_t++; end
                        check("enable_drop_latency", ctl_t, 1);
                        repeat (ctl_r.rel) @(negedge clk);
                        b.wr_done = 0;
                        b.rd_done = 0;
                    end
                end
            end
        end
    end

    // Monitor: every res_valid pulse consumes one expected record.
    res_t mon_e;
    always @(negedge clk) begin
        if (!rst && b.res_valid) begin
            if (res_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_res_valid: got pulse expected none");
            end else begin
                mon_e = res_q.pop_front();
                check("res_rhash", b.res_rhash, mon_e.rhash);
                check("res_rd_cycles", b.res_rd_cycles, mon_e.rd);
                check("res_wr_cycles", b.res_wr_cycles, mon_e.wr);
                check("res_iters", b.res_iters, mon_e.iters);
                check("res_err", b.res_err, mon_e.err);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {b.cmd_ready, b.wr_enable, b.rd_enable, b.busy, b.res_valid, b.res_err}, 0);
        check({tag, "_params"}, {b.start_addr, b.burst_len}, 0);
        check({tag, "_wval"}, b.write_val, 0);
        check({tag, "_res"}, {b.res_rhash, b.res_iters}, 0);
        check({tag, "_acc"}, {b.res_rd_cycles, b.res_wr_cycles}, 0);
    endtask

    initial begin
        b.cmd_valid = 0; b.cmd_mode = 0; b.cmd_addr = 0; b.cmd_len = 0; b.cmd_val = 0; b.cmd_iter = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", b.cmd_ready, 1);

        run_cmd(2'd0, 32'h100, 32'd63, 32'hA5A5_0000, 16'd3);
        check("wo_last_addr", b.start_addr, 32'h180);
        check("wo_last_val", b.write_val, 32'hA5A5_0002);
        check("wo_iters", b.res_iters, 3);

        fix_en = 1; fix_wc = 32'd40; fix_rc = 32'd55; fix_h = 32'h1234_5678;
        run_cmd(2'd2, 32'h2000, 32'd15, 32'h1, 16'd1);
        fix_en = 0;
        check("wtr_wr_cycles", b.res_wr_cycles, 40);
        check("wtr_rd_cycles", b.res_rd_cycles, 55);
        check("wtr_rhash", b.res_rhash, 32'h1234_5678);

        run_cmd(2'd3, 32'h0, 32'h0, 32'h0, 16'd5);
        check("illegal_err_held", b.res_err, 1);
        run_cmd(2'd1, 32'h500, 32'd7, 32'h0, 16'd0);
        check("zero_iter_iters", b.res_iters, 1);

        run_cmd(2'd0, 32'h3FFF_FFC0, 32'd127, 32'h5, 16'd2);
        check("wrap_addr", b.start_addr, 32'h40);

        // reset while the read run is outstanding
        run_q.push_back('{1'b1, 32'h777, 32'd3, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1});
        issue(2'd1, 32'h777, 32'd3, 32'h0, 16'd2);
        @(negedge clk);
        check("rd_run_before_reset", b.rd_enable, 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrun_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_runs_consumed", run_q.size(), 0);
        run_cmd(2'd1, 32'h900, 32'd31, 32'h0, 16'd2);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] len;
            len = $urandom_range(0, 255) | ($urandom_range(0, 1) == 1 ? 32'hC000_0000 : 32'h0);
            run_cmd(2'($urandom_range(0, 3)), $urandom, len, $urandom, 16'($urandom_range(0, 4)));
        end

`ifdef DRAM_PERF_SEQ_TIMEOUT_EN
        begin
            int t;
            run_q.push_back('{1'b1, 32'h40, 32'd0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1});
            res_q.push_back('{32'h0, 48'h0, 48'h0, 16'h0, 1'b1});
            issue(2'd1, 32'h40, 32'd0, 32'h0, 16'd1);
            t = 0;
            while (!b.res_valid && t < 100) begin
                if (b.rd_enable) t++;
                @(negedge clk);
            end
            check("timeout_enable_cycles", t, 20);
            check("timeout_rd_enable", b.rd_enable, 0);
            repeat (5) @(negedge clk);
            check("err_cmd_ready", b.cmd_ready, 0);
            check("err_busy", b.busy, 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check("ready_after_err_reset", b.cmd_ready, 1);
        end
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
